// File: rtl/iq_age_select_pkg.sv
// Shared issue-queue types and sizing for the age-ordered select logic.
// Also used by the schedule stage and recovery manager.
package iq_age_select_pkg;

    localparam int unsigned IQ_ENTRY_NUM       = 16;
    localparam int unsigned IQ_INDEX_BIT_WIDTH = 4;
    localparam int unsigned DISPATCH_WIDTH     = 2;
    localparam int unsigned NUM_PORTS          = 4;

    typedef logic [IQ_INDEX_BIT_WIDTH-1:0] IssueQueueIndexPath;
    typedef logic [IQ_ENTRY_NUM-1:0]       IssueQueueOneHotPath;

    // age[i][j] = 1 means entry i is older than entry j
    typedef logic [IQ_ENTRY_NUM-1:0][IQ_ENTRY_NUM-1:0] age_matrix_t;

    // Column e of the age matrix: every entry recorded as older than e.
    // The diagonal is forced to 0 so an entry never blocks itself.
    function automatic IssueQueueOneHotPath age_column(input age_matrix_t age, input int unsigned e);
        IssueQueueOneHotPath col;
        col = '0;
        for (int unsigned j = 0; j < IQ_ENTRY_NUM; j++) begin
            col[j] = (j != e) && age[j][e];
        end
        return col;
    endfunction

endpackage

// File: rtl/iq_age_select_age_oldest_pick.sv
// Combinational oldest-one picker over a single eligibility vector.
// Ports:
//   eligible  in   candidate entries for this port
//   age       in   pairwise age matrix
//   found_c   out  at least one candidate exists
//   oldest_c  out  one-hot of the oldest candidate (zero when none)
//   ptr_c     out  index of the oldest candidate (zero when none)
module age_oldest_pick
    import iq_age_select_pkg::*;
(
    input  IssueQueueOneHotPath eligible,
    input  age_matrix_t         age,
    output logic                found_c,
    output IssueQueueOneHotPath oldest_c,
    output IssueQueueIndexPath  ptr_c
);

    // An entry is oldest when no other candidate is older than it; the age
    // matrix is a total order over valid entries, so at most one bit is set
    // and an OR-encode yields its index.
    always_comb begin
        oldest_c = '0;
        ptr_c    = '0;
        found_c  = |eligible;
        for (int unsigned i = 0; i < IQ_ENTRY_NUM; i++) begin
            oldest_c[i] = eligible[i] && ((eligible & age_column(age, i)) == '0);
        end
        for (int unsigned i = 0; i < IQ_ENTRY_NUM; i++) begin
            if (oldest_c[i]) begin
                ptr_c = ptr_c | IssueQueueIndexPath'(i);
            end
        end
    end

endmodule

// File: rtl/iq_age_select.sv
// Oldest-first issue select: tracks IQ occupancy and a pairwise age matrix,
// and grants up to NUM_PORTS ready entries per cycle, oldest first, with no
// entry granted to two ports.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   stall          suppresses all grants (state updates still happen)
//   dispatch       per-slot allocate strobe; slot 0 is older than slot 1
//   dispatchPtr    entry index per slot, slot k at [k*W +: W]
//   release_mask   entries freed this cycle
//   request        per-port eligibility, port p at [p*IQ_ENTRY_NUM +: IQ_ENTRY_NUM]
//   selected       grant valid per port
//   selectedPtr    granted entry per port, port p at [p*W +: W]
//   entryValid     current occupancy
//   protocolError  sticky flag for dispatch onto a live or duplicated entry
module iq_age_select
    import iq_age_select_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       stall,
    input  logic [DISPATCH_WIDTH-1:0]                  dispatch,
    input  logic [DISPATCH_WIDTH*IQ_INDEX_BIT_WIDTH-1:0] dispatchPtr,
    input  logic [IQ_ENTRY_NUM-1:0]                    release_mask,
    input  logic [NUM_PORTS*IQ_ENTRY_NUM-1:0]          request,
    output logic [NUM_PORTS-1:0]                       selected,
    output logic [NUM_PORTS*IQ_INDEX_BIT_WIDTH-1:0]    selectedPtr,
    output logic [IQ_ENTRY_NUM-1:0]                    entryValid,
    output logic                                       protocolError
);

    IssueQueueOneHotPath valid_q, valid_d;
    age_matrix_t         age_q, age_d;
    logic                perr_q, perr_d;

    // Next-state: release first, then dispatch slots in order so a later slot
    // sees earlier slots as older and overrides them on a duplicate pointer.
    always_comb begin
        IssueQueueOneHotPath older;
        IssueQueueIndexPath  ptr;
        valid_d = valid_q & ~release_mask;
        age_d   = age_q;
        perr_d  = perr_q;
        older   = valid_q & ~release_mask;
        ptr     = '0;
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            ptr = dispatchPtr[k*IQ_INDEX_BIT_WIDTH +: IQ_INDEX_BIT_WIDTH];
            if (dispatch[k]) begin
                // Target still live or already claimed by an earlier slot
                if (older[ptr]) begin
                    perr_d = 1'b1;
                end
                // New entry is younger than everything: empty row, full column.
                // Later slots rewrite their own column, restoring age[ptr][later].
                age_d[ptr] = '0;
                for (int unsigned j = 0; j < IQ_ENTRY_NUM; j++) begin
                    age_d[j][ptr] = older[j] && (IssueQueueIndexPath'(j) != ptr);
                end
                valid_d[ptr] = 1'b1;
                older[ptr]   = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            age_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            perr_q  <= perr_d;
        end
    end

    assign entryValid    = valid_q;
    assign protocolError = perr_q;

    // Port chain: each port excludes entries already granted to lower ports.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        IssueQueueOneHotPath taken_in;
        IssueQueueOneHotPath eligible;
        IssueQueueOneHotPath oldest;
        IssueQueueIndexPath  ptr;
        logic                found;

        if (p == 0) begin : g_head
            assign taken_in = '0;
        end else begin : g_tail
            assign taken_in = g_port[p-1].g_fwd.taken_out;
        end

        assign eligible = request[p*IQ_ENTRY_NUM +: IQ_ENTRY_NUM] & valid_q & ~taken_in;

        age_oldest_pick u_pick (
            .eligible (eligible),
            .age      (age_q),
            .found_c  (found),
            .oldest_c (oldest),
            .ptr_c    (ptr)
        );

        if (p + 1 < NUM_PORTS) begin : g_fwd
            IssueQueueOneHotPath taken_out;
            assign taken_out = taken_in | oldest;
        end

        assign selected[p] = found && !stall;
        assign selectedPtr[p*IQ_INDEX_BIT_WIDTH +: IQ_INDEX_BIT_WIDTH] =
            (found && !stall) ? ptr : '0;
    end

endmodule

// File: tb/tb_iq_age_select.sv
// Self-checking bench for iq_age_select: directed scenarios plus randomized
// traffic against an ordered-queue reference model (front = oldest).
module tb_iq_age_select;
    import iq_age_select_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall;
    logic [1:0]  dispatch;
    logic [7:0]  dispatchPtr;
    logic [15:0] release_mask;
    logic [63:0] request;
    logic [3:0]  selected;
    logic [15:0] selectedPtr;
    logic [15:0] entryValid;
    logic        protocolError;

    int checks;
    int failures;
    int q[$];
    bit m_perr;

    always #5 clk = ~clk;

    iq_age_select dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .dispatch      (dispatch),
        .dispatchPtr   (dispatchPtr),
        .release_mask  (release_mask),
        .request       (request),
        .selected      (selected),
        .selectedPtr   (selectedPtr),
        .entryValid    (entryValid),
        .protocolError (protocolError)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_valid();
        logic [15:0] v;
        v = '0;
        foreach (q[n]) v[q[n]] = 1'b1;
        return v;
    endfunction

    // Walk the age queue oldest-first for each port, skipping taken entries
    function automatic void model_select(input logic [63:0] req, input logic st,
                                         output logic [3:0] s, output logic [15:0] ptrs);
        logic [15:0] taken;
        taken = '0;
        s     = '0;
        ptrs  = '0;
        if (!st) begin
            for (int p = 0; p < 4; p++) begin
                foreach (q[n]) begin
                    if (!s[p] && req[p*16 + q[n]] && !taken[q[n]]) begin
                        s[p]            = 1'b1;
                        ptrs[p*4 +: 4]  = 4'(q[n]);
                        taken[q[n]]     = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic model_update();
        int nq[$];
        int e;
        foreach (q[n]) if (!release_mask[q[n]]) nq.push_back(q[n]);
        q = nq;
        for (int k = 0; k < 2; k++) begin
            if (dispatch[k]) begin
                e = int'(dispatchPtr[k*4 +: 4]);
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i] == e) begin
                        q.delete(i);
                        m_perr = 1'b1;
                        break;
                    end
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic clear_inputs();
        stall        = 1'b0;
        dispatch     = '0;
        dispatchPtr  = '0;
        release_mask = '0;
        request      = '0;
    endtask

    task automatic disp(input int k, input int e);
        dispatch[k]           = 1'b1;
        dispatchPtr[k*4 +: 4] = 4'(e);
    endtask

    // Compare all outputs mid-cycle, then advance model and DUT one edge
    task automatic do_cycle();
        logic [3:0]  es;
        logic [15:0] ep;
        @(negedge clk);
        model_select(request, stall, es, ep);
        check("selected", selected, es);
        check("selectedPtr", selectedPtr, ep);
        check("entryValid", entryValid, model_valid());
        check("protocolError", protocolError, m_perr);
        model_update();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must clear immediately, whatever the inputs
    task automatic do_reset();
        rst = 1'b1;
        #1;
        request  = {$urandom, $urandom};
        stall    = 1'b0;
        #1;
        check("rst_selected", selected, 0);
        check("rst_selectedPtr", selectedPtr, 0);
        check("rst_entryValid", entryValid, 0);
        check("rst_protocolError", protocolError, 0);
        q.delete();
        m_perr = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic int perm(input int i);
        return (5 * i + 3) % 16;
    endfunction

    initial begin
        logic [15:0] vnow;
        logic [15:0] avail;
        logic [15:0] used;
        logic [15:0] rel;
        int e;
        int start;
        checks   = 0;
        failures = 0;
        m_perr   = 1'b0;
        clear_inputs();

        // Reset release: 3 (slot 0) and 7 (slot 1), not selectable until next cycle
        do_reset();
        disp(0, 3); disp(1, 7); request = '1;
        do_cycle();
        dispatch = '0;
        #1;
        check("t1_selected", selected, 4'b0011);
        check("t1_ptr0", selectedPtr[3:0], 3);
        check("t1_ptr1", selectedPtr[7:4], 7);
        do_cycle();

        // Age order: 5, then 2, then 9
        do_reset();
        disp(0, 5); do_cycle();
        clear_inputs(); disp(0, 2); do_cycle();
        clear_inputs(); disp(0, 9); do_cycle();
        clear_inputs();
        request[2] = 1'b1; request[9] = 1'b1;
        request[16+5] = 1'b1; request[16+2] = 1'b1; request[16+9] = 1'b1;
        #1;
        check("t2_selected", selected, 4'b0011);
        check("t2_ptr0", selectedPtr[3:0], 2);
        check("t2_ptr1", selectedPtr[7:4], 5);
        do_cycle();

        // Release and re-dispatch 4 in one cycle: 4 becomes younger than 6
        do_reset();
        disp(0, 4); disp(1, 6); do_cycle();
        clear_inputs(); release_mask[4] = 1'b1; disp(0, 4); do_cycle();
        clear_inputs(); request[4] = 1'b1; request[6] = 1'b1;
        #1;
        check("t3_selected", selected, 4'b0001);
        check("t3_ptr0", selectedPtr[3:0], 6);
        check("t3_perr", protocolError, 0);
        do_cycle();

        // Stall hides grants; they return unchanged when it drops
        do_reset();
        disp(0, 1); disp(1, 2); do_cycle();
        clear_inputs(); disp(0, 3); do_cycle();
        clear_inputs(); request = '1; stall = 1'b1;
        #1;
        check("t4_stall_selected", selected, 0);
        check("t4_stall_ptr", selectedPtr, 0);
        do_cycle();
        do_cycle();
        stall = 1'b0;
        #1;
        check("t4_selected", selected, 4'b0111);
        check("t4_ptrs", selectedPtr, 16'h0321);
        do_cycle();

        // Illegal dispatch onto live entry 1: sticky error, 1 becomes youngest
        do_reset();
        disp(0, 1); disp(1, 8); do_cycle();
        clear_inputs(); disp(0, 1);
        #1;
        check("t5_perr_before", protocolError, 0);
        do_cycle();
        clear_inputs(); request = '1;
        #1;
        check("t5_perr", protocolError, 1);
        check("t5_ptr0", selectedPtr[3:0], 8);
        check("t5_ptr1", selectedPtr[7:4], 1);
        for (int i = 0; i < 3; i++) begin
            request = {$urandom, $urandom};
            do_cycle();
        end
        do_reset();

        // Fill all 16 entries, then drain oldest four per cycle
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            disp(0, perm(2*c)); disp(1, perm(2*c + 1));
            do_cycle();
        end
        clear_inputs(); request = '1;
        #1;
        check("t6_full", entryValid, 16'hFFFF);
        for (int g = 0; g < 4; g++) begin
            clear_inputs(); request = '1;
            for (int i = 0; i < 4; i++) release_mask[perm(4*g + i)] = 1'b1;
            #1;
            check("t6_drain_selected", selected, 4'hF);
            check("t6_drain_ptr0", selectedPtr[3:0], perm(4*g));
            check("t6_drain_ptr3", selectedPtr[15:12], perm(4*g + 3));
            do_cycle();
        end
        clear_inputs(); request = '1;
        #1;
        check("t6_empty_valid", entryValid, 0);
        check("t6_empty_selected", selected, 0);
        do_cycle();

        // Randomized traffic with periodic mid-operation resets
        for (int n = 0; n < 1500; n++) begin
            if (n % 300 == 299) do_reset();
            clear_inputs();
            stall   = ($urandom_range(0, 7) == 0);
            request = {$urandom, $urandom};
            vnow    = model_valid();
            rel     = '0;
            for (int i = 0; i < 16; i++) begin
                if (vnow[i] && $urandom_range(0, 3) == 0) rel[i] = 1'b1;
            end
            release_mask = rel;
            used = '0;
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    e = -1;
                    if ($urandom_range(0, 31) == 0) begin
                        e = int'($urandom_range(0, 15));
                    end else begin
                        avail = (~vnow | rel) & ~used;
                        start = int'($urandom_range(0, 15));
                        for (int i = 0; i < 16; i++) begin
                            if (e < 0 && avail[(start + i) % 16]) e = (start + i) % 16;
                        end
                    end
                    if (e >= 0) begin
                        disp(k, e);
                        used[e] = 1'b1;
                    end
                end
            end
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
